fishingrod_host_if: RTL and testbench

Host-side framing and sequencing stage for the parallel Fishingrod core. It accepts key and plaintext words over a valid/ready bus, holds them in shadow registers, fires the single-cycle `start` that the Fishingrod control unit requires, waits for the core's `ready`, then captures the ciphertext and streams it back out word by word. It sits directly upstream of the control unit's `start` input and downstream of its `ready` output.

---
 rtl/fishingrod_host_if.sv | 196 +++++++++++++++++++
 tb/tb_fishingrod_host_if.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fishingrod_host_if.sv
// fishingrod_host_if
// Host-side framing stage for the Fishingrod core: collects key and plaintext
// words MSB first, fires a one-cycle start, waits for the core's done flag and
// streams the captured ciphertext back out one word at a time.
// Optional feature macro: FISHINGROD_HOST_KEYREUSE_EN adds the keep_key port,
// which lets a frame reuse the previously loaded key.
module fishingrod_host_if #(
    parameter int BLOCK_W = 64,
    parameter int KEY_W   = 128,
    parameter int BUS_W   = 16
) (
    input  logic               ck,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [BUS_W-1:0]   in_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [BUS_W-1:0]   out_data,
    output logic               start,
    input  logic               core_ready,
    output logic [KEY_W-1:0]   core_key,
    output logic [BLOCK_W-1:0] core_din,
    input  logic [BLOCK_W-1:0] core_dout,
`ifdef FISHINGROD_HOST_KEYREUSE_EN
    input  logic               keep_key,
`endif
    output logic               busy
);

    localparam int KEY_WORDS  = KEY_W / BUS_W;
    localparam int DATA_WORDS = BLOCK_W / BUS_W;
    localparam int MAX_WORDS  = (KEY_WORDS > DATA_WORDS) ? KEY_WORDS : DATA_WORDS;
    localparam int CNT_W      = $clog2(MAX_WORDS) + 1;

    // The IDLE beat already holds key word 0, so LOAD_KEY ends one word early.
    localparam logic [CNT_W-1:0] KEY_LAST      = CNT_W'((KEY_WORDS > 1) ? KEY_WORDS - 2 : 0);
    localparam logic [CNT_W-1:0] DATA_LAST     = CNT_W'(DATA_WORDS - 1);
    // Data phase entered with data word 0 already taken (key reuse).
    localparam logic [CNT_W-1:0] DATA_LAST_PRE = CNT_W'((DATA_WORDS > 1) ? DATA_WORDS - 2 : 0);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD_KEY,
        S_LOAD_DATA,
        S_START,
        S_RUN,
        S_DRAIN
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               in_ready_q, in_ready_d;
    logic [KEY_W-1:0]   key_q, key_d;
    logic [BLOCK_W-1:0] din_q, din_d;
    logic [BLOCK_W-1:0] out_q, out_d;
    logic               data_pre_q, data_pre_d;
    logic               beat;
    logic               reuse_req;

    assign beat = in_valid && in_ready_q;

`ifdef FISHINGROD_HOST_KEYREUSE_EN
    logic key_loaded_q, key_loaded_d;

    // Remember that some frame has completed loading since reset, so a key exists to reuse.
    always_comb begin
        key_loaded_d = key_loaded_q | (state_d == S_START);
        reuse_req    = keep_key && key_loaded_q;
    end

    // Key-valid flag register.
    always_ff @(posedge ck or posedge rst) begin
        if (rst) begin
            key_loaded_q <= 1'b0;
        end else begin
            key_loaded_q <= key_loaded_d;
        end
    end
`else
    assign reuse_req = 1'b0;
`endif

    // Next-state, counter and shadow-register updates for the framing sequence.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        key_d      = key_q;
        din_d      = din_q;
        out_d      = out_q;
        data_pre_d = data_pre_q;
        case (state_q)
            S_IDLE: begin
                if (beat) begin
                    cnt_d = '0;
                    if (reuse_req) begin
                        din_d = (din_q << BUS_W) | BLOCK_W'(in_data);
                        if (DATA_WORDS == 1) begin
                            state_d    = S_START;
                            data_pre_d = 1'b0;
                        end else begin
                            state_d    = S_LOAD_DATA;
                            data_pre_d = 1'b1;
                        end
                    end else begin
                        key_d      = (key_q << BUS_W) | KEY_W'(in_data);
                        data_pre_d = 1'b0;
                        state_d    = (KEY_WORDS == 1) ? S_LOAD_DATA : S_LOAD_KEY;
                    end
                end
            end
            S_LOAD_KEY: begin
                if (beat) begin
                    key_d = (key_q << BUS_W) | KEY_W'(in_data);
                    if (cnt_q == KEY_LAST) begin
                        state_d = S_LOAD_DATA;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            S_LOAD_DATA: begin
                if (beat) begin
                    din_d = (din_q << BUS_W) | BLOCK_W'(in_data);
                    if (cnt_q == (data_pre_q ? DATA_LAST_PRE : DATA_LAST)) begin
                        state_d = S_START;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            S_START: begin
                state_d = S_RUN;
                cnt_d   = '0;
            end
            S_RUN: begin
                // First RUN cycle ignores core_ready: it may still be the previous done flag.
                if (cnt_q == '0) begin
                    cnt_d = CNT_W'(1);
                end else if (core_ready) begin
                    out_d   = core_dout;
                    state_d = S_DRAIN;
                    cnt_d   = '0;
                end
            end
            S_DRAIN: begin
                if (out_ready) begin
                    out_d = out_q << BUS_W;
                    if (cnt_q == DATA_LAST) begin
                        state_d = S_IDLE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
        in_ready_d = (state_d == S_IDLE) || (state_d == S_LOAD_KEY) || (state_d == S_LOAD_DATA);
    end

    // State and datapath registers; reset aborts any frame in flight.
    always_ff @(posedge ck or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            in_ready_q <= 1'b0;
            key_q      <= '0;
            din_q      <= '0;
            out_q      <= '0;
            data_pre_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            in_ready_q <= in_ready_d;
            key_q      <= key_d;
            din_q      <= din_d;
            out_q      <= out_d;
            data_pre_q <= data_pre_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign busy      = (state_q != S_IDLE);
    assign start     = (state_q == S_START);
    assign out_valid = (state_q == S_DRAIN);
    assign out_data  = out_q[BLOCK_W-1 -: BUS_W];
    assign core_key  = key_q;
    assign core_din  = din_q;

endmodule

// File: tb/tb_fishingrod_host_if.sv
// Bench for fishingrod_host_if: randomized frames, a reference core model and
// a scoreboard monitor that checks operands, start timing and output words.
module tb_fishingrod_host_if;

    logic         ck = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic [15:0]  in_data = '0;
    logic         out_ready = 1'b0;
    logic         core_ready = 1'b1;
    logic [63:0]  core_dout = 64'h0BAD_0BAD_0BAD_0BAD;
    logic         keep_key = 1'b0;
    logic         in_ready, out_valid, start, busy;
    logic [15:0]  out_data;
    logic [127:0] core_key;
    logic [63:0]  core_din;

    fishingrod_host_if #(.BLOCK_W(64), .KEY_W(128), .BUS_W(16)) dut (
        .ck         (ck),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .start      (start),
        .core_ready (core_ready),
        .core_key   (core_key),
        .core_din   (core_din),
        .core_dout  (core_dout),
`ifdef FISHINGROD_HOST_KEYREUSE_EN
        .keep_key   (keep_key),
`endif
        .busy       (busy)
    );

    always #5 ck = ~ck;

    int cyc = 0;
    always @(posedge ck) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference cipher of the model core (any fixed mixing function will do).
    function automatic logic [63:0] cipher(input logic [127:0] k, input logic [63:0] d);
        return d ^ k[63:0] ^ {k[119:64], k[127:120]} ^ 64'h0123_4567_89AB_CDEF;
    endfunction

    // Scoreboard queues filled by the driver.
    logic [127:0] exp_key_q[$];
    logic [63:0]  exp_din_q[$];
    int           exp_start_q[$];
    bit           exp_force_q[$];
    logic [15:0]  exp_out_q[$];

    // Host-level model state.
    bit           key_loaded = 0;
    logic [127:0] model_key = '0;

    logic [127:0] held_key = '0;
    logic [63:0]  held_din = '0;

    task automatic send_word(input logic [15:0] w, input bit kk, input int gap, output int acc_cyc);
        bit acc;
        int t;
        acc_cyc = 0;
        repeat (gap) begin
            @(posedge ck); #1;
        end
        in_valid = 1'b1;
        in_data  = w;
        keep_key = kk;
        t = 0;
        forever begin
            @(negedge ck);
            acc     = in_ready;
            acc_cyc = cyc;
            @(posedge ck); #1;
            if (acc) break;
            t++;
            if (t > 2000) begin
                n_cmp++;
                n_bad++;
                $display("FAIL beat_timeout: in_ready never seen, word %0h", w);
                break;
            end
        end
        in_valid = 1'b0;
        keep_key = 1'b0;
    endtask

    task automatic send_frame(input logic [127:0] key, input logic [63:0] data, input bit keep,
                              input int max_gap, input bit force_ct);
        bit reuse;
        int c;
        logic [63:0] ct;
        reuse = 1'b0;
`ifdef FISHINGROD_HOST_KEYREUSE_EN
        reuse = keep && key_loaded;
`endif
        if (!reuse) begin
            for (int i = 0; i < 8; i++)
                send_word(key[127-16*i -: 16], (i == 0) ? keep : 1'b0, $urandom_range(0, max_gap), c);
            model_key = key;
        end
        for (int i = 0; i < 4; i++)
            send_word(data[63-16*i -: 16], reuse && (i == 0), $urandom_range(0, max_gap), c);
        key_loaded = 1;
        exp_key_q.push_back(model_key);
        exp_din_q.push_back(data);
        exp_start_q.push_back(c + 1);
        exp_force_q.push_back(force_ct);
        ct = force_ct ? 64'hDEAD_BEEF_CAFE_F00D : cipher(model_key, data);
        for (int i = 0; i < 4; i++) exp_out_q.push_back(ct[63-16*i -: 16]);
    endtask

    // Model core: stale done flag survives into the first RUN cycle, then random latency.
    initial begin
        logic [63:0] nd;
        int lat;
        forever begin
            @(negedge ck);
            if (!rst && start) begin
                if (exp_key_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_start: no frame pending");
                    nd = cipher(core_key, core_din);
                end else begin
                    check("core_key", core_key, exp_key_q.pop_front());
                    check("core_din", {64'h0, core_din}, {64'h0, exp_din_q.pop_front()});
                    check("start_cycle", cyc, exp_start_q.pop_front());
                    nd = exp_force_q.pop_front() ? 64'hDEAD_BEEF_CAFE_F00D : cipher(core_key, core_din);
                end
                held_key = core_key;
                held_din = core_din;
                @(posedge ck); #1;
                @(posedge ck); #1;
                lat = $urandom_range(0, 3);
                if (lat > 0) begin
                    core_ready = 1'b0;
                    repeat (lat) @(posedge ck);
                    #1;
                end
                core_dout  = nd;
                core_ready = 1'b1;
            end
        end
    end

    // Host sink: directed stall pattern on the first stream, random afterwards.
    initial begin
        bit pat [7] = '{1, 0, 0, 1, 0, 1, 1};
        out_ready = pat[0];
        do @(negedge ck); while (!out_valid);
        for (int i = 1; i < 7; i++) begin
            @(posedge ck); #1;
            out_ready = pat[i];
        end
        forever begin
            @(posedge ck); #1;
            out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    // Output monitor: scoreboard pops, stall stability, operand stability, frame end.
    initial begin
        bit          stall_prev = 0;
        bit          start_prev = 0;
        bit          idle_expect = 0;
        logic [15:0] held_word = '0;
        int          words = 0;
        forever begin
            @(negedge ck);
            if (!rst) begin
                if (start) check("start_width", start_prev, 0);
                if (stall_prev) begin
                    check("stall_valid", out_valid, 1);
                    check("stall_data", out_data, held_word);
                end
                if (idle_expect) begin
                    check("drain_end_valid", out_valid, 0);
                    check("drain_end_busy", busy, 0);
                    idle_expect = 0;
                end
                if (out_valid) begin
                    check("key_stable", core_key, held_key);
                    check("din_stable", {64'h0, core_din}, {64'h0, held_din});
                end
                if (out_valid && out_ready) begin
                    if (exp_out_q.size() == 0) begin
                        n_cmp++;
                        n_bad++;
                        $display("FAIL extra_word: got %0h with nothing expected", out_data);
                    end else begin
                        check("out_word", out_data, exp_out_q.pop_front());
                    end
                    words++;
                    if (words % 4 == 0) idle_expect = 1;
                end
                stall_prev = out_valid && !out_ready;
                held_word  = out_data;
                start_prev = start;
            end
        end
    end

    // Main stimulus sequence.
    initial begin
        int c;
        int t;
        logic [127:0] rk;
        logic [63:0]  rd;

        // Reset values.
        @(posedge ck); @(posedge ck); #1;
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_start", start, 0);
        check("rst_busy", busy, 0);
        check("rst_core_key", core_key, 0);
        check("rst_core_din", {64'h0, core_din}, 0);
        rst = 1'b0;
        @(posedge ck); @(negedge ck);
        check("rel_in_ready", in_ready, 1);
        check("rel_busy", busy, 0);
        @(posedge ck); #1;

        // Partial frame: full key then 3 data words, aborted by reset.
        for (int i = 0; i < 11; i++) send_word(16'(i * 16'h1111 + 16'h0101), 1'b0, 0, c);
        rst = 1'b1;
        #1;
        check("abort_busy", busy, 0);
        check("abort_in_ready", in_ready, 0);
        check("abort_start", start, 0);
        @(posedge ck); #1;
        rst = 1'b0;
        key_loaded = 0;
        @(posedge ck); @(negedge ck);
        check("abort_rel_in_ready", in_ready, 1);
        check("abort_rel_busy", busy, 0);
        @(posedge ck); #1;

        // Directed back-to-back frame, fixed ciphertext; keep_key here must fall back to a key load.
        send_frame(128'h0001_0203_0405_0607_0809_0A0B_0C0D_0E0F, 64'h0011_2233_4455_6677, 1'b1, 0, 1'b1);

        // Key-reuse frame (full load when the feature is absent).
        send_frame(128'hFFEE_DDCC_BBAA_9988_7766_5544_3322_1100, 64'h8899_AABB_CCDD_EEFF, 1'b1, 0, 1'b0);

        // Randomized frames with input gaps.
        for (int f = 0; f < 20; f++) begin
            rk = {$urandom, $urandom, $urandom, $urandom};
            rd = {$urandom, $urandom};
            send_frame(rk, rd, ($urandom_range(0, 1) == 1), 3, 1'b0);
        end

        t = 0;
        while (exp_out_q.size() != 0 && t < 3000) begin
            @(posedge ck);
            t++;
        end
        @(negedge ck); @(negedge ck);
        check("pending_words", exp_out_q.size(), 0);
        check("pending_starts", exp_key_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
